// File: rtl/io_serial_port.sv
// Serial character I/O stage: UART-style receiver feeding INPR/FGI and
// transmitter driven by OUT, with FGO ready flag and interrupt request.
module io_serial_port #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       inp_rd,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       out_wr,
  input  logic [7:0] out_data,
  output logic       fgo,
  input  logic       ien,
  output logic       irq,
  output logic       rx_overrun,
  output logic       frame_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
  logic [2:0]    rx_sync_q, rx_sync_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [TW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    inpr_q, inpr_d;
  logic          fgi_q, fgi_d, ovr_q, ovr_d, ferr_q, ferr_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [TW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d, fgo_q, fgo_d;
  logic          rx_s, rx_fall, rx_done;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], rx};
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end
      RX_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d   = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + TW'(1);
      RX_DATA: if (rx_cnt_q == LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + TW'(1);
      default: if (rx_cnt_q == LAST) begin
        rx_cnt_d   = '0;
        rx_done    = 1'b1;
        rx_state_d = RX_IDLE;
      end else rx_cnt_d = rx_cnt_q + TW'(1);
    endcase
  end

  // A completing byte overrides a same-cycle read: the CPU just emptied INPR.
  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (inp_rd) begin
      fgi_d  = 1'b0;
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (rx_done) begin
      if (!rx_s) ferr_d = 1'b1;
      else if (!fgi_q || inp_rd) begin
        inpr_d = rx_sh_q;
        fgi_d  = 1'b1;
      end else ovr_d = 1'b1;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    fgo_d      = fgo_q;
    case (tx_state_q)
      TX_IDLE: if (out_wr) begin
        tx_sh_d    = out_data;
        tx_d       = 1'b0;
        fgo_d      = 1'b0;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_SEND;
      end
      default: if (tx_cnt_q == LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_state_d = TX_IDLE;
          fgo_d      = 1'b1;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q < 4'd8) begin
            tx_d    = tx_sh_q[0];
            tx_sh_d = {1'b0, tx_sh_q[7:1]};
          end else tx_d = 1'b1;
        end
      end else tx_cnt_d = tx_cnt_q + TW'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q  <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      inpr_q     <= '0;
      fgi_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      fgo_q      <= 1'b1;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      inpr_q     <= inpr_d;
      fgi_q      <= fgi_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      fgo_q      <= fgo_d;
    end
  end

  assign tx         = tx_q;
  assign fgo        = fgo_q;
  assign inpr       = inpr_q;
  assign fgi        = fgi_q;
  assign rx_overrun = ovr_q;
  assign frame_err  = ferr_q;
  assign irq        = ien & (fgi_q | fgo_q);
endmodule

// File: tb/tb_io_serial_port.sv
// Bench for io_serial_port: receive table, directed TX/loopback/reset
// sequences, and random concurrent RX+TX frames against a flag model.
module tb_io_serial_port;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rx_drv, lb, inp_rd, out_wr, ien;
  logic [7:0] out_data;
  logic       rx_w, tx, fgi, fgo, irq, rx_overrun, frame_err;
  logic [7:0] inpr;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       rd;
    logic [7:0] e_inpr;
    logic       e_fgi;
    logic       e_ovr;
    logic       e_ferr;
  } rx_vec_t;
  rx_vec_t tbl [6];

  logic [7:0] m_inpr;
  logic       m_fgi, m_ovr, m_ferr;

  assign rx_w = lb ? tx : rx_drv;
  always #5 clk = ~clk;

  io_serial_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx_w), .tx(tx), .inp_rd(inp_rd), .inpr(inpr),
    .fgi(fgi), .out_wr(out_wr), .out_data(out_data), .fgo(fgo), .ien(ien),
    .irq(irq), .rx_overrun(rx_overrun), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {7'd0, act}, {7'd0, exp});
  endtask

  task automatic check_rx(input logic [7:0] e_inpr, input logic e_fgi,
                          input logic e_ovr, input logic e_ferr);
    check("inpr", inpr, e_inpr);
    check1("fgi", fgi, e_fgi);
    check1("rx_overrun", rx_overrun, e_ovr);
    check1("frame_err", frame_err, e_ferr);
  endtask

  task automatic rd_pulse();
    @(posedge clk); #1 inp_rd = 1'b1;
    @(posedge clk); #1 inp_rd = 1'b0;
  endtask

  // Drive one 10-bit frame on rx, then idle high for a few cycles.
  task automatic rx_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_drv = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx_drv = stop;
    repeat (CPB) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Issue OUT and check every cycle of the resulting waveform plus fgo timing.
  task automatic tx_frame(input logic [7:0] d, input logic extra_wr);
    logic exp_b;
    int   ok;
    @(posedge clk); #1 out_wr = 1'b1; out_data = d;
    @(posedge clk); #1 out_wr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
      ok = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (tx === exp_b) ok++;
        if (k == 0 && c == 0) check1("fgo_busy", fgo, 1'b0);
        if (extra_wr && k == 3 && c == 2) begin out_wr = 1'b1; out_data = 8'hFF; end
        if (extra_wr && k == 3 && c == 3) out_wr = 1'b0;
      end
      check("tx_bit_cycles", 8'(ok), 8'(CPB));
    end
    check1("fgo_stop_end", fgo, 1'b0);
    @(posedge clk); #1;
    check1("fgo_ready", fgo, 1'b1);
    check1("tx_idle", tx, 1'b1);
  endtask

  initial begin
    tbl[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h22, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h77, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h99, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'hC3, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 1'b1};

    rst = 1'b0; rx_drv = 1'b1; lb = 1'b0; inp_rd = 1'b0;
    out_wr = 1'b0; out_data = 8'h00; ien = 1'b0;

    // Asynchronous reset mid-cycle, checked before any clock edge acts on it.
    #12 rst = 1'b1;
    #1;
    check1("rst_tx", tx, 1'b1);
    check1("rst_fgo", fgo, 1'b1);
    check_rx(8'h00, 1'b0, 1'b0, 1'b0);
    check1("irq_ien0", irq, 1'b0);
    ien = 1'b1; #1;
    check1("irq_ien1", irq, 1'b1);
    ien = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);

    tx_frame(8'hA5, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rx_frame(tbl[i].d, tbl[i].stop);
      check_rx(tbl[i].e_inpr, tbl[i].e_fgi, tbl[i].e_ovr, tbl[i].e_ferr);
      if (tbl[i].rd) begin
        rd_pulse();
        check_rx(tbl[i].e_inpr, 1'b0, 1'b0, 1'b0);
      end
    end

    // Read strobe lands exactly on the stop-sample edge of a frame.
    rx_frame(8'h44, 1'b1);
    check_rx(8'h44, 1'b1, 1'b0, 1'b0);
    fork
      rx_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 inp_rd = 1'b1;
        @(posedge clk); #1 inp_rd = 1'b0;
      end
    join
    check_rx(8'h55, 1'b1, 1'b0, 1'b0);

    // Short low glitch must not start a frame.
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_rx(8'h55, 1'b1, 1'b0, 1'b0);
    rd_pulse();
    rx_frame(8'h66, 1'b1);
    check_rx(8'h66, 1'b1, 1'b0, 1'b0);
    rd_pulse();

    // Loopback, then reset in the middle of a second looped frame.
    lb = 1'b1;
    tx_frame(8'h5A, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check_rx(8'h5A, 1'b1, 1'b0, 1'b0);
    ien = 1'b1;
    @(posedge clk); #1 out_wr = 1'b1; out_data = 8'hC3;
    @(posedge clk); #1 out_wr = 1'b0;
    repeat (4 * CPB + 4) @(posedge clk);
    check1("fgo_mid", fgo, 1'b0);
    check1("irq_fgi", irq, 1'b1);
    #3 rst = 1'b1;
    #1;
    check1("rst_mid_tx", tx, 1'b1);
    check1("rst_mid_fgo", fgo, 1'b1);
    check_rx(8'h00, 1'b0, 1'b0, 1'b0);
    ien = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    tx_frame(8'hC7, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check_rx(8'hC7, 1'b1, 1'b0, 1'b0);
    lb = 1'b0;

    // Random concurrent RX and TX frames against the flag model.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_inpr = 8'h00; m_fgi = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    for (int it = 0; it < 10; it++) begin
      logic [7:0] dr, dt;
      logic       st;
      dr = 8'($urandom);
      dt = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      fork
        tx_frame(dt, 1'b0);
        rx_frame(dr, st);
      join
      if (!st) m_ferr = 1'b1;
      else if (m_fgi) m_ovr = 1'b1;
      else begin m_inpr = dr; m_fgi = 1'b1; end
      check_rx(m_inpr, m_fgi, m_ovr, m_ferr);
      if ($urandom_range(0, 1) == 1) begin
        rd_pulse();
        m_fgi = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        check_rx(m_inpr, m_fgi, m_ovr, m_ferr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
